// File: rtl/onehot_encode_16_to_4.sv
// Sequential 16-to-4 encoder: captures a select vector and emits one index per accepted beat.
// Define ONEHOT_ENCODE_ROUND_ROBIN_EN for rotating-pointer selection instead of lowest-first.
module onehot_encode_16_to_4 #(
    parameter int unsigned N_LINES = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [N_LINES-1:0] req_in,
    input  logic               req_valid,
    output logic               req_ready,
    output logic [IDX_W-1:0]   enc_out,
    output logic               enc_valid,
    output logic               enc_last,
    input  logic               enc_ready,
    output logic               zero_req,
    output logic               multi_hot,
    output logic [IDX_W:0]     pend_cnt
);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    localparam logic [IDX_W:0] CntOne = (IDX_W+1)'(1);

    state_e               state_q, state_d;
    logic [N_LINES-1:0]   pend_q, pend_d;
    logic [IDX_W:0]       cnt_q, cnt_d;
    logic                 multi_q, multi_d;
    logic                 zero_q, zero_d;
    logic [IDX_W-1:0]     sel_idx;

    function automatic logic [IDX_W:0] popcount(input logic [N_LINES-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < N_LINES; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

`ifdef ONEHOT_ENCODE_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Pointer addition wraps naturally because N_LINES == 2**IDX_W.
    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_LINES; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!found && pend_q[cand]) begin
                sel_idx = cand;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StDrain && enc_ready) begin
            ptr_d = sel_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        multi_d = multi_q;
        zero_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_in == '0) begin
                        zero_d  = 1'b1;
                        multi_d = 1'b0;
                    end else begin
                        pend_d  = req_in;
                        cnt_d   = popcount(req_in);
                        multi_d = (popcount(req_in) > CntOne);
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (enc_ready) begin
                    pend_d[sel_idx] = 1'b0;
                    cnt_d           = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= StIdle;
            pend_q  <= '0;
            cnt_q   <= '0;
            multi_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            multi_q <= multi_d;
            zero_q  <= zero_d;
        end
    end

    // Outputs depend on registered state only; enc_ready and req_in never reach them.
    assign req_ready = (state_q == StIdle);
    assign enc_valid = (state_q == StDrain);
    assign enc_last  = (state_q == StDrain) && (cnt_q == CntOne);
    assign enc_out   = sel_idx;
    assign zero_req  = zero_q;
    assign multi_hot = multi_q;
    assign pend_cnt  = cnt_q;

endmodule
